// File: rtl/issue_scoreboard_pkg.sv
// Shared sizing and the issue-record bundle for the issue-slice register scoreboard.
package issue_scoreboard_pkg;

    localparam int unsigned NUM_WIS  = 4;
    localparam int unsigned NUM_REGS = 64;
    localparam int unsigned PAYLOADW = 128;

    function automatic int unsigned log2up(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned WIS_W   = log2up(NUM_WIS);
    localparam int unsigned NR_BITS = log2up(NUM_REGS);

    typedef struct packed {
        logic [WIS_W-1:0]    wis;
        logic                wb;
        logic [NR_BITS-1:0]  rd;
        logic [NR_BITS-1:0]  rs1;
        logic [NR_BITS-1:0]  rs2;
        logic [NR_BITS-1:0]  rs3;
        logic [PAYLOADW-1:0] payload;
    } issue_rec_t;

endpackage

// File: rtl/issue_scoreboard_pipe_reg.sv
// One-entry valid/ready pipe register; reset clears valid only, data is left unreset.
module scoreboard_pipe_reg #(
    parameter int unsigned DATAW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enq,
    input  logic [DATAW-1:0] enq_data,
    input  logic             deq_ready,
    output logic             ready,
    output logic             valid,
    output logic [DATAW-1:0] data
);

    logic             valid_q;
    logic             valid_d;
    logic [DATAW-1:0] data_q;

    assign ready = !valid_q || deq_ready;
    assign valid = valid_q;
    assign data  = data_q;

    always_comb begin
        valid_d = valid_q;
        if (enq) begin
            valid_d = 1'b1;
        end else if (deq_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            data_q <= enq_data;
        end
    end

endmodule

// File: rtl/issue_scoreboard.sv
// Per-issue-slice register scoreboard with stall watchdog.
// Define SCOREBOARD_BYPASS_EN to let a same-cycle eop writeback unblock the waiting instruction.
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIS_W-1:0]    in_wis,
    input  logic                in_wb,
    input  logic [NR_BITS-1:0]  in_rd,
    input  logic [NR_BITS-1:0]  in_rs1,
    input  logic [NR_BITS-1:0]  in_rs2,
    input  logic [NR_BITS-1:0]  in_rs3,
    input  logic [PAYLOADW-1:0] in_payload,

    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIS_W-1:0]    out_wis,
    output logic                out_wb,
    output logic [NR_BITS-1:0]  out_rd,
    output logic [NR_BITS-1:0]  out_rs1,
    output logic [NR_BITS-1:0]  out_rs2,
    output logic [NR_BITS-1:0]  out_rs3,
    output logic [PAYLOADW-1:0] out_payload,

    input  logic                wb_valid,
    input  logic [WIS_W-1:0]    wb_wis,
    input  logic [NR_BITS-1:0]  wb_rd,
    input  logic                wb_eop,

    output logic                stall_timeout
);

    localparam int unsigned     CNT_W   = log2up(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    issue_rec_t in_rec;
    issue_rec_t out_rec;
    logic       pipe_ready;
    logic       hz;
    logic       accept;

    logic [NUM_WIS-1:0][NUM_REGS-1:0] pending_q;
    logic [NUM_WIS-1:0][NUM_REGS-1:0] pending_d;
    logic [NUM_REGS-1:0]              cur_pending;

    logic [CNT_W-1:0] wd_cnt_q;
    logic [CNT_W-1:0] wd_cnt_d;
    logic             stall_timeout_q;
    logic             stall_timeout_d;

    always_comb begin
        in_rec.wis     = in_wis;
        in_rec.wb      = in_wb;
        in_rec.rd      = in_rd;
        in_rec.rs1     = in_rs1;
        in_rec.rs2     = in_rs2;
        in_rec.rs3     = in_rs3;
        in_rec.payload = in_payload;
    end

    // Hazard view of the requesting warp slot.
`ifdef SCOREBOARD_BYPASS_EN
    logic [NUM_REGS-1:0] release_mask;

    always_comb begin
        release_mask = '0;
        if (wb_valid && wb_eop && (wb_wis == in_wis)) begin
            release_mask[wb_rd] = 1'b1;
        end
    end

    assign cur_pending = pending_q[in_wis] & ~release_mask;
`else
    assign cur_pending = pending_q[in_wis];
`endif

    assign hz = (in_wb && cur_pending[in_rd]) || cur_pending[in_rs1]
             || cur_pending[in_rs2] || cur_pending[in_rs3];

    assign in_ready = pipe_ready && !hz;
    assign accept   = in_valid && in_ready;

    scoreboard_pipe_reg #(
        .DATAW ($bits(issue_rec_t))
    ) u_pipe (
        .clk       (clk),
        .reset     (reset),
        .enq       (accept),
        .enq_data  (in_rec),
        .deq_ready (out_ready),
        .ready     (pipe_ready),
        .valid     (out_valid),
        .data      (out_rec)
    );

    assign out_wis     = out_rec.wis;
    assign out_wb      = out_rec.wb;
    assign out_rd      = out_rec.rd;
    assign out_rs1     = out_rec.rs1;
    assign out_rs2     = out_rec.rs2;
    assign out_rs3     = out_rec.rs3;
    assign out_payload = out_rec.payload;

    // Set is applied after clear so a coincident set on the same entry wins.
    always_comb begin
        pending_d = pending_q;
        if (wb_valid && wb_eop) begin
            pending_d[wb_wis][wb_rd] = 1'b0;
        end
        if (accept && in_wb && (in_rd != '0)) begin
            pending_d[in_wis][in_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // The counter sticks at CNT_MAX; one more stalled cycle there raises the flag.
    always_comb begin
        wd_cnt_d        = wd_cnt_q;
        stall_timeout_d = stall_timeout_q;
        if (accept || !in_valid) begin
            wd_cnt_d = '0;
        end else if (hz) begin
            if (wd_cnt_q == CNT_MAX) begin
                stall_timeout_d = 1'b1;
            end else begin
                wd_cnt_d = wd_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_q        <= '0;
            stall_timeout_q <= 1'b0;
        end else begin
            wd_cnt_q        <= wd_cnt_d;
            stall_timeout_q <= stall_timeout_d;
        end
    end

    assign stall_timeout = stall_timeout_q;

endmodule
